// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into instructions and writes them
// at consecutive addresses. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    len,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               im_we,
   output logic [ADDR_W-1:0]  im_addr,
   output logic [INSTR_W-1:0] im_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               cpu_hold
);
   localparam int unsigned HI_W  = INSTR_W - 8;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
      S_WR   = 3'd3,
      S_CHK  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [HI_W-1:0]    hi_q, hi_d;
   logic               in_ready_d, im_we_d, busy_d, done_d, err_d, cpu_hold_d;
   logic [ADDR_W-1:0]  im_addr_d;
   logic [INSTR_W-1:0] im_wdata_d;
   logic               xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif

   assign xfer = in_valid && in_ready;

   // Next state plus next value of every registered output; Moore outputs follow state_d.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      hi_d       = hi_q;
      im_addr_d  = im_addr;
      im_wdata_d = im_wdata;
      err_d      = err;
      cpu_hold_d = cpu_hold;
      in_ready_d = 1'b0;
      im_we_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               len_d      = len;
               idx_d      = '0;
               err_d      = 1'b0;
               cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
               state_d    = (len == '0) ? S_CHK : S_HI;
`else
               state_d    = (len == '0) ? S_FIN : S_HI;
`endif
            end
         end
         S_HI: begin
            if (xfer) begin
               if (in_data[7]) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  hi_d    = in_data[HI_W-1:0];
                  state_d = S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d  = csum_q ^ in_data;
`endif
               end
            end
         end
         S_LO: begin
            if (xfer) begin
               im_addr_d  = base_q + idx_q[ADDR_W-1:0];
               im_wdata_d = {hi_q, in_data};
               idx_d      = idx_q + CNT_W'(1);
               state_d    = S_WR;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ in_data;
`endif
            end
         end
         S_WR: begin
            // idx_q was already advanced when the low byte was taken
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = (idx_q == len_q) ? S_CHK : S_HI;
`else
            state_d = (idx_q == len_q) ? S_FIN : S_HI;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) begin
               if (in_data == csum_q) begin
                  state_d = S_FIN;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
`endif
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CHK);
      im_we_d    = (state_d == S_WR);
      busy_d     = in_ready_d || im_we_d;
      done_d     = (state_d == S_FIN);
      if (done_d) cpu_hold_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         hi_q     <= '0;
         in_ready <= 1'b0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         hi_q     <= hi_d;
         in_ready <= in_ready_d;
         im_we    <= im_we_d;
         im_addr  <= im_addr_d;
         im_wdata <= im_wdata_d;
         busy     <= busy_d;
         done     <= done_d;
         err      <= err_d;
         cpu_hold <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random loads compared against a queue model of the
// expected write list (address base+i modulo 256, data {opcode, literal}) and done/hold timing.
module tb_imem_loader;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 15;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int DONE_LAT = 2;
`else
   localparam int DONE_LAT = 1;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [ADDR_W-1:0]  base_addr;
   logic [ADDR_W:0]    len;
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               im_we;
   logic [ADDR_W-1:0]  im_addr;
   logic [INSTR_W-1:0] im_wdata;
   logic               busy;
   logic               done;
   logic               err;
   logic               cpu_hold;

   int n_cmp  = 0;
   int n_fail = 0;

   // observation state, written only by the monitor
   int          cyc          = 0;
   int          done_cnt     = 0;
   int          done_cyc     = -1;
   int          last_we_cyc  = -1;
   int          dbl_we       = 0;
   logic        hold_at_done = 1'b1;
   logic        we_prev      = 1'b0;
   logic [22:0] wr_q[$];

   // stimulus words for the next load: {opcode[6:0], literal[7:0]}
   logic [14:0] stim_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .im_we(im_we),
      .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done), .err(err),
      .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      we_prev <= im_we;
      if (im_we) begin
         wr_q.push_back({im_addr, im_wdata});
         last_we_cyc <= cyc + 1;
         if (we_prev) dbl_we <= dbl_we + 1;
      end
      if (done) begin
         done_cnt     <= done_cnt + 1;
         done_cyc     <= cyc + 1;
         hold_at_done <= cpu_hold;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one byte after `stall` idle cycles and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b, input int stall, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({tag, " byte accepted"}, 32'(got), 32'(1));
   endtask

   // Present start for one sampling edge; s is the monitor cycle in which it is sampled.
   task automatic start_load(input logic [7:0] b, input int n, output int s);
      base_addr = b;
      len       = 9'(n);
      start     = 1'b1;
      @(negedge clk); #1;
      s = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = 8'($urandom);
      len       = 9'($urandom);
   endtask

   task automatic fill_rand(input int n);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(15'($urandom));
   endtask

   // Full load of stim_q at base; poke drives a competing start while the load is busy.
   task automatic run_load(input logic [7:0] base, input int st_lo, input int st_hi,
                           input bit poke, input string tag);
      int n  = stim_q.size();
      int w0 = wr_q.size();
      int d0 = done_cnt;
      int s;
      int waited = 0;
      logic [7:0] hb, lb;
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] ck = 8'h00;
`endif
      start_load(base, n, s);
      if (n > 0) chk({tag, " hold on start"}, 32'(cpu_hold), 32'(1));
      chk({tag, " err cleared by start"}, 32'(err), 32'(0));
      for (int i = 0; i < n; i++) begin
         hb = {1'b0, stim_q[i][14:8]};
         lb = stim_q[i][7:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
         ck = ck ^ hb ^ lb;
`endif
         send_byte(hb, $urandom_range(st_hi, st_lo), tag);
         if (poke && i == 0) begin
            start     = 1'b1;
            base_addr = ~base;
            len       = 9'd3;
         end
         send_byte(lb, $urandom_range(st_hi, st_lo), tag);
      end
      start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(ck, 0, tag);
`endif
      while (done_cnt == d0 && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      chk({tag, " done pulses"}, 32'(done_cnt - d0), 32'(1));
      chk({tag, " write count"}, 32'(wr_q.size() - w0), 32'(n));
      for (int i = 0; i < n && w0 + i < wr_q.size(); i++)
         chk({tag, " write addr/data"}, 32'(wr_q[w0 + i]),
             32'({8'(int'(base) + i), stim_q[i]}));
      if (n == 0) chk({tag, " done latency from start"}, 32'(done_cyc - s), 32'(DONE_LAT));
      else        chk({tag, " done after last write"}, 32'(done_cyc - last_we_cyc), 32'(DONE_LAT));
      chk({tag, " hold falls with done"}, 32'(hold_at_done), 32'(0));
      chk({tag, " final err/busy/hold"}, 32'({err, busy, cpu_hold}), 32'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int s, w0, d0, j0, bad;
      int cnt[256];
      logic [7:0] b;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      base_addr = '0; len = '0;
      repeat (3) @(posedge clk); #1;
      chk("reset flags", 32'({in_ready, im_we, busy, done, err, cpu_hold}), 32'(6'b000001));
      chk("reset addr/data", 32'({im_addr, im_wdata}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // two words from base 0, source never idles
      stim_q = '{15'h1234, 15'h05FF};
      run_load(8'h00, 0, 0, 1'b0, "basic");

      // reset asserted between the high and low byte of the first word
      w0 = wr_q.size();
      start_load(8'h10, 3, s);
      send_byte(8'h21, 0, "rstmid");
      #2 rst = 1'b1;
      #1;
      chk("rstmid flags", 32'({in_ready, im_we, busy, done, err, cpu_hold}), 32'(6'b000001));
      chk("rstmid addr/data", 32'({im_addr, im_wdata}), 32'(0));
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rstmid no write", 32'(wr_q.size() - w0), 32'(0));

      // base 0xFF wraps to 0x00; four idle cycles before every byte
      fill_rand(2);
      run_load(8'hFF, 4, 4, 1'b0, "wrap stall");

      stim_q.delete();
      run_load(8'($urandom), 0, 0, 1'b0, "len0");

      // framing error on the first high byte
      w0 = wr_q.size();
      d0 = done_cnt;
      start_load(8'h33, 3, s);
      send_byte(8'h80, 0, "frame");
      chk("frame err", 32'(err), 32'(1));
      chk("frame idle", 32'({busy, in_ready}), 32'(0));
      chk("frame hold", 32'(cpu_hold), 32'(1));
      repeat (3) @(posedge clk); #1;
      chk("frame no write", 32'(wr_q.size() - w0), 32'(0));
      chk("frame no done", 32'(done_cnt - d0), 32'(0));

      // next start must clear err
      fill_rand(3);
      run_load(8'($urandom), 0, 2, 1'b0, "after frame");

      for (int k = 0; k < 6; k++) begin
         fill_rand($urandom_range(6, 1));
         b = 8'($urandom);
         run_load(b, 0, 3, k == 2, "rand");
      end

      // every location once, starting away from 0
      fill_rand(256);
      run_load(8'($urandom_range(255, 1)), 0, 0, 1'b0, "full");
      for (int a = 0; a < 256; a++) cnt[a] = 0;
      j0 = (wr_q.size() >= 256) ? wr_q.size() - 256 : 0;
      for (int j = j0; j < wr_q.size(); j++) cnt[wr_q[j][22:15]]++;
      bad = 0;
      for (int a = 0; a < 256; a++) if (cnt[a] != 1) bad++;
      chk("full each address once", 32'(bad), 32'(0));

`ifdef IMEM_LOADER_CHECKSUM_EN
      stim_q = '{15'h1234};
      run_load(8'h00, 0, 0, 1'b0, "ck match");
      d0 = done_cnt;
      start_load(8'h00, 1, s);
      send_byte(8'h12, 0, "ck bad");
      send_byte(8'h34, 0, "ck bad");
      send_byte(8'h27, 0, "ck bad");
      repeat (4) @(negedge clk); #1;
      chk("ck bad err", 32'(err), 32'(1));
      chk("ck bad no done", 32'(done_cnt - d0), 32'(0));
      chk("ck bad hold", 32'(cpu_hold), 32'(1));
`endif

      chk("im_we single-cycle", 32'(dbl_we), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish within 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
